// File: rtl/bcd_pkg.sv
// Shared types and constants for the double-dabble binary-to-BCD converter.
package bcd_pkg;

    localparam int unsigned BCD_DIGIT_W = 4;
    localparam logic [BCD_DIGIT_W-1:0] DABBLE_THRESH = 4'd5;
    localparam logic [BCD_DIGIT_W-1:0] DABBLE_ADD = 4'd3;

    typedef enum logic [1:0] {
        StIdle,
        StShift,
        StDone
    } state_e;

endpackage

// File: rtl/bcd_digit_adjust.sv
// One BCD digit of the dabble step: add 3 when the digit is 5 or more, so the
// following left shift carries correctly into the next decimal digit.
module bcd_digit_adjust
    import bcd_pkg::*;
(
    input  logic [BCD_DIGIT_W-1:0] digit_i,
    output logic [BCD_DIGIT_W-1:0] digit_o
);

    always_comb begin
        digit_o = digit_i;
        if (digit_i >= DABBLE_THRESH) begin
            digit_o = digit_i + DABBLE_ADD;
        end
    end

endmodule

// File: rtl/bin2bcd_dabble.sv
// Sequential shift-add-3 binary-to-BCD converter, one input bit per clock, with
// registered BCD result, one-cycle done pulse and sticky overflow flag.
module bin2bcd_dabble
    import bcd_pkg::*;
#(
    parameter int unsigned P_BIN_W  = 9,
    parameter int unsigned P_DIGITS = 4
) (
    input  logic                           i_clock_50mhz,
    input  logic                           i_reset,
    input  logic                           i_start,
    input  logic [P_BIN_W-1:0]             i_bin,
    output logic                           o_busy,
    output logic                           o_done,
    output logic [BCD_DIGIT_W*P_DIGITS-1:0] o_bcd,
    output logic                           o_overflow
);

    localparam int unsigned ScrW = BCD_DIGIT_W * P_DIGITS;
    localparam int unsigned CntW = (P_BIN_W > 1) ? $clog2(P_BIN_W) : 1;
    localparam logic [CntW-1:0] CntLoad = CntW'(P_BIN_W - 1);

    state_e              state_q, state_d;
    logic [P_BIN_W-1:0]  bin_sr_q, bin_sr_d;
    logic [ScrW-1:0]     scratch_q, scratch_d;
    logic                ovf_q, ovf_d;
    logic [CntW-1:0]     cnt_q, cnt_d;
    logic [ScrW-1:0]     bcd_q, bcd_d;
    logic                ovf_out_q, ovf_out_d;
    logic                done_q, done_d;

    logic [ScrW-1:0]     adjusted;
    logic [ScrW-1:0]     scratch_step;
    logic                carry;

    for (genvar g = 0; g < P_DIGITS; g++) begin : g_adjust
        bcd_digit_adjust u_adjust (
            .digit_i (scratch_q[g*BCD_DIGIT_W +: BCD_DIGIT_W]),
            .digit_o (adjusted[g*BCD_DIGIT_W +: BCD_DIGIT_W])
        );
    end

    // The bit leaving the top digit is the part of the value the display cannot hold.
    always_comb begin
        carry        = adjusted[ScrW-1];
        scratch_step = {adjusted[ScrW-2:0], bin_sr_q[P_BIN_W-1]};
    end

    always_comb begin
        state_d   = state_q;
        bin_sr_d  = bin_sr_q;
        scratch_d = scratch_q;
        ovf_d     = ovf_q;
        cnt_d     = cnt_q;
        bcd_d     = bcd_q;
        ovf_out_d = ovf_out_q;
        done_d    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (i_start) begin
                    bin_sr_d  = i_bin;
                    scratch_d = '0;
                    ovf_d     = 1'b0;
                    cnt_d     = CntLoad;
                    state_d   = StShift;
                end
            end
            StShift: begin
                bin_sr_d  = bin_sr_q << 1;
                scratch_d = scratch_step;
                ovf_d     = ovf_q | carry;
                cnt_d     = cnt_q - 1'b1;
                if (cnt_q == '0) begin
                    bcd_d     = scratch_step;
                    ovf_out_d = ovf_q | carry;
                    done_d    = 1'b1;
                    state_d   = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge i_clock_50mhz) begin
        if (!i_reset) begin
            state_q   <= StIdle;
            bin_sr_q  <= '0;
            scratch_q <= '0;
            ovf_q     <= 1'b0;
            cnt_q     <= '0;
            bcd_q     <= '0;
            ovf_out_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            bin_sr_q  <= bin_sr_d;
            scratch_q <= scratch_d;
            ovf_q     <= ovf_d;
            cnt_q     <= cnt_d;
            bcd_q     <= bcd_d;
            ovf_out_q <= ovf_out_d;
            done_q    <= done_d;
        end
    end

    always_comb begin
        o_busy     = (state_q != StIdle);
        o_done     = done_q;
        o_bcd      = bcd_q;
        o_overflow = ovf_out_q;
    end

endmodule

// File: tb/tb_bin2bcd_dabble.sv
// Directed bench for bin2bcd_dabble: a 4-digit and a 2-digit instance, expected
// results queued at start and compared when o_done fires.
module tb_bin2bcd_dabble;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start_a = 1'b0;
    logic [8:0]  bin_a = '0;
    logic        busy_a, done_a, ovf_a;
    logic [15:0] bcd_a;
    logic        start_b = 1'b0;
    logic [8:0]  bin_b = '0;
    logic        busy_b, done_b, ovf_b;
    logic [7:0]  bcd_b;

    int total = 0;
    int bad = 0;
    int edge_cnt = 0;
    logic [16:0] q_a[$];
    logic [16:0] q_b[$];

    always #10 clk = ~clk;

    bin2bcd_dabble #(.P_BIN_W(9), .P_DIGITS(4)) u_dut_a (
        .i_clock_50mhz (clk),
        .i_reset       (rst_n),
        .i_start       (start_a),
        .i_bin         (bin_a),
        .o_busy        (busy_a),
        .o_done        (done_a),
        .o_bcd         (bcd_a),
        .o_overflow    (ovf_a)
    );

    bin2bcd_dabble #(.P_BIN_W(9), .P_DIGITS(2)) u_dut_b (
        .i_clock_50mhz (clk),
        .i_reset       (rst_n),
        .i_start       (start_b),
        .i_bin         (bin_b),
        .o_busy        (busy_b),
        .o_done        (done_b),
        .o_bcd         (bcd_b),
        .o_overflow    (ovf_b)
    );

    // Reference: decimal digits by division, overflow when anything is left over.
    function automatic logic [16:0] model(input int v, input int digits);
        logic [15:0] b;
        int r;
        b = '0;
        r = v;
        for (int d = 0; d < digits; d++) begin
            b[d*4 +: 4] = 4'(r % 10);
            r = r / 10;
        end
        return {(r != 0), b};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        edge_cnt++;
        @(negedge clk);
    endtask

    task automatic start_conv(input int sel, input int v, input bit push);
        if (sel == 0) begin
            start_a = 1'b1;
            bin_a = 9'(v);
            if (push) q_a.push_back(model(v, 4));
        end else begin
            start_b = 1'b1;
            bin_b = 9'(v);
            if (push) q_b.push_back(model(v, 2));
        end
        tick();
        start_a = 1'b0;
        start_b = 1'b0;
        // Scramble the input to prove only the accepting edge captures it.
        bin_a = 9'($urandom);
        bin_b = 9'($urandom);
        chk("busy_after_accept", {31'd0, (sel == 0) ? busy_a : busy_b}, 32'd1);
    endtask

    task automatic score(input int sel, input string tag);
        logic [16:0] e;
        if (sel == 0) begin
            chk({tag, "_sb_nonempty"}, {31'd0, q_a.size() != 0}, 32'd1);
            if (q_a.size() != 0) begin
                e = q_a.pop_front();
                chk({tag, "_bcd"}, {16'd0, bcd_a}, {16'd0, e[15:0]});
                chk({tag, "_ovf"}, {31'd0, ovf_a}, {31'd0, e[16]});
            end
        end else begin
            chk({tag, "_sb_nonempty"}, {31'd0, q_b.size() != 0}, 32'd1);
            if (q_b.size() != 0) begin
                e = q_b.pop_front();
                chk({tag, "_bcd"}, {24'd0, bcd_b}, {24'd0, e[7:0]});
                chk({tag, "_ovf"}, {31'd0, ovf_b}, {31'd0, e[16]});
            end
        end
    endtask

    // Waits for o_done; exp_lat counts remaining edges after the caller's last tick.
    task automatic wait_done(input int sel, input string tag, input int exp_lat);
        int k;
        logic d;
        k = 0;
        d = (sel == 0) ? done_a : done_b;
        while (!d && k < 40) begin
            tick();
            k++;
            d = (sel == 0) ? done_a : done_b;
        end
        chk({tag, "_done_seen"}, {31'd0, d}, 32'd1);
        if (d) begin
            chk({tag, "_latency"}, k, exp_lat);
            score(sel, tag);
            tick();
            chk({tag, "_done_drop"}, {31'd0, (sel == 0) ? done_a : done_b}, 32'd0);
            chk({tag, "_idle"}, {31'd0, (sel == 0) ? busy_a : busy_b}, 32'd0);
        end
    endtask

    task automatic quiet(input string tag, input int n);
        int c;
        c = 0;
        for (int i = 0; i < n; i++) begin
            tick();
            if (done_a || done_b) c++;
        end
        chk(tag, c, 0);
    endtask

    initial begin
        int last_done;
        repeat (3) tick();
        chk("rst_busy_a", {31'd0, busy_a}, 32'd0);
        chk("rst_done_a", {31'd0, done_a}, 32'd0);
        chk("rst_bcd_a", {16'd0, bcd_a}, 32'd0);
        chk("rst_ovf_a", {31'd0, ovf_a}, 32'd0);
        chk("rst_bcd_b", {24'd0, bcd_b}, 32'd0);
        rst_n = 1'b1;
        tick();

        start_conv(0, 0, 1'b1);
        wait_done(0, "zero", 9);
        start_conv(0, 511, 1'b1);
        wait_done(0, "v511", 9);
        start_conv(0, 100, 1'b1);
        wait_done(0, "v100", 9);
        start_conv(0, 9, 1'b1);
        wait_done(0, "v9", 9);

        // Start re-asserted at E3 with a new value must be ignored.
        start_conv(0, 300, 1'b1);
        tick();
        tick();
        start_a = 1'b1;
        bin_a = 9'd7;
        tick();
        start_a = 1'b0;
        wait_done(0, "busy_start", 6);
        quiet("busy_start_no_second", 15);
        chk("busy_start_hold", {16'd0, bcd_a}, 32'h0300);

        // Reset asserted at E5 of a 511 conversion discards it.
        start_conv(0, 511, 1'b0);
        repeat (4) tick();
        rst_n = 1'b0;
        tick();
        chk("midrst_bcd", {16'd0, bcd_a}, 32'd0);
        chk("midrst_busy", {31'd0, busy_a}, 32'd0);
        chk("midrst_done", {31'd0, done_a}, 32'd0);
        rst_n = 1'b1;
        quiet("midrst_no_done", 15);
        start_conv(0, 42, 1'b1);
        wait_done(0, "v42", 9);

        start_conv(1, 99, 1'b1);
        wait_done(1, "b99", 9);
        start_conv(1, 100, 1'b1);
        wait_done(1, "b100", 9);
        start_conv(1, 511, 1'b1);
        wait_done(1, "b511", 9);

        // Start held high: accepts at relative edges 0, 11, 22.
        last_done = -1;
        start_a = 1'b1;
        bin_a = 9'd123;
        for (int i = 0; i < 30; i++) begin
            if (i % 11 == 0) q_a.push_back(model(123, 4));
            tick();
            if (done_a) begin
                if (last_done >= 0) chk("held_gap", edge_cnt - last_done, 11);
                last_done = edge_cnt;
                score(0, "held");
            end
        end
        start_a = 1'b0;
        wait_done(0, "held_last", 2);
        chk("held_final_gap", edge_cnt - 1 - last_done, 11);

        chk("sb_a_drained", q_a.size(), 0);
        chk("sb_b_drained", q_b.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/bin2bcd_dabble.md
Name: bin2bcd_dabble

Overview:
Sequential double-dabble (shift-add-3) converter that turns the switch-driven binary value into packed BCD digits for the seven-segment decoder stage directly downstream. It accepts a start request, converts one bit per clock, then presents registered BCD digits with a one-cycle done pulse. Digits beyond the display range are flagged by a sticky overflow bit. It runs in the 50 MHz board clock domain.

Parameters:
P_BIN_W, 9, width of the binary input (matches the 9 value switches).
P_DIGITS, 4, number of BCD digits produced (one per HEX display).

Ports:
i_clock_50mhz  input  1  system clock, 50 MHz, rising edge.
i_reset  input  1  synchronous, active-low reset (0 = reset, sampled on the clock edge).
i_start  input  1  conversion request, sampled only in IDLE.
i_bin  input  P_BIN_W  unsigned binary value, captured on the accepting edge.
o_busy  output  1  high in SHIFT and DONE; low only in IDLE.
o_done  output  1  one-cycle pulse; o_bcd and o_overflow are valid and new.
o_bcd  output  4*P_DIGITS  packed BCD, digit 0 in [3:0]; held until the next o_done.
o_overflow  output  1  value exceeded 10^P_DIGITS-1; updated together with o_bcd.

Behaviour:
- Reset: i_reset==0 at any edge forces state IDLE, o_bcd=0, o_done=0, o_busy=0, o_overflow=0, and clears the internal shift and scratch registers. This applies mid-conversion; the partial result is discarded.
- FSM IDLE -> SHIFT -> DONE -> IDLE.
- IDLE: if i_start==1 at edge E0, load bin_sr=i_bin, scratch=0, ovf_scratch=0, bit counter=P_BIN_W-1, and go to SHIFT. If i_start==0, stay in IDLE.
- SHIFT, edges E1..E(P_BIN_W), one step per edge:
  - Every scratch digit >=5 gets +3.
  - Then shift {scratch, bin_sr} left by 1.
  - The bit shifted out of the MSB of the top digit ORs into ovf_scratch.
  - The counter decrements each step.
- At edge E(P_BIN_W), the final step's result is written straight to o_bcd and ovf_scratch|final carry to o_overflow. o_done=1 and state goes to DONE.
- Latency: o_done is high in the cycle following edge E(P_BIN_W), i.e. P_BIN_W edges after the accepting edge. With defaults, o_done is high in the cycle following E9.
- DONE: lasts exactly one cycle. o_done drops and state returns to IDLE at the next edge.
- Start handling:
  - i_start is ignored in SHIFT and DONE; no queuing.
  - Back-to-back throughput is one conversion per P_BIN_W+2 cycles (start must be re-asserted in IDLE).
  - i_start held high continuously restarts on every IDLE cycle.
- Input capture: i_bin is captured only at E0. Later changes do not affect the conversion in flight.
- Overflow: when o_overflow=1, o_bcd holds value mod 10^P_DIGITS (the exact low digits).
- o_bcd and o_overflow change only at the DONE-entry edge or at reset.
- Width rules: scratch is 4*P_DIGITS bits, and each digit compare/add is 4-bit unsigned. The counter is clog2(P_BIN_W) bits wide.
- P_BIN_W must be >=1 and P_DIGITS >=1; other values are unsupported.

Decomposition:
- Shared package bcd_pkg holds:
  - the state enum (IDLE, SHIFT, DONE);
  - constant BCD_DIGIT_W=4;
  - constant DABBLE_THRESH=5;
  - constant DABBLE_ADD=3.
- Sub-module bcd_digit_adjust: 4-bit combinational add-3-if->=5, generated P_DIGITS times inside the SHIFT datapath.
- The FSM, counter and registers stay in bin2bcd_dabble.

Test Plan:
- Defaults, i_bin=0, start pulse → o_done high exactly 9 edges after the accepting edge, o_bcd=16'h0000, o_overflow=0, o_busy low again one cycle later.
- Defaults, i_bin=511 → o_bcd=16'h0511, o_overflow=0. i_bin=9'd100 → 16'h0100. i_bin=9'd9 → 16'h0009.
- Start while busy: i_start pulsed again at E3 with i_bin changed to 7 after capturing 300 → single o_done, o_bcd=16'h0300, no second conversion.
- Reset mid-operation: i_reset=0 at E5 of a 511 conversion → o_bcd=0, o_busy=0, no o_done. A fresh start of 42 then yields 16'h0042.
- P_DIGITS=2, P_BIN_W=9: i_bin=99 → o_bcd=8'h99, overflow 0. i_bin=100 → 8'h00, overflow 1. i_bin=511 → 8'h11, overflow 1.
- i_start held high for 30 cycles with defaults, i_bin=123 → o_done pulses every 11 cycles, each time with 16'h0123.
